// File: rtl/dmem_responder_if.sv
// Load/store handshake bundle between the memory stage (master) and the data-memory responder (slave).
// Requests and responses each use their own valid/ready pair.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-granular data-memory target: one request in flight, programmable wait states,
// byte-lane write strobes and a full-word read response.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  load_ok_q, load_ok_d;

    logic                  we_q;
    logic [29:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;

    logic                  req_fire;
    logic                  resp_fire;
    logic                  access;
    logic                  be_legal;
    logic                  out_of_range;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word;

    // Ready is masked by the reset level so it stays low for the whole reset pulse.
    assign bus.req_ready  = (state_q == S_IDLE) && rst;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = load_ok_q ? rd_word : 32'h0;

    assign req_fire  = bus.req_valid && bus.req_ready;
    assign resp_fire = bus.resp_valid && bus.resp_ready;

    assign out_of_range = |addr_q[29:ADDR_WIDTH];
    assign word_idx     = addr_q[ADDR_WIDTH-1:0];
    assign access       = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign commit       = access && we_q && !out_of_range && be_legal;

    always_comb begin
        be_legal = 1'b0;
        case (be_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            load_ok_q <= load_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        load_ok_d = load_ok_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = S_RESP;
                    err_d     = out_of_range || !be_legal;
                    load_ok_d = !we_q && !out_of_range && be_legal;
                end
            end
            S_RESP: begin
                if (resp_fire) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b0;
                    load_ok_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured only on acceptance, so bus changes later are ignored.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[31:2];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // One byte-wide RAM per lane keeps strobed writes a plain single-port write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (commit && be_q[gi]) begin
                    lane_mem[word_idx] <= wdata_q[8*gi +: 8];
                end
                if (access) begin
                    lane_rd_q <= lane_mem[word_idx];
                end
            end

            assign rd_word[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

endmodule
